// File: rtl/unbitreverse.sv
// Reorders a bit-reversed FFT frame stream into natural order using a ping-pong
// frame memory; frame alignment is taken from i_sync and violations pulse o_err.
module unbitreverse #(
   parameter int LGSIZE = 5,
   parameter int WIDTH  = 24
) (
   input  logic                 i_clk,
   input  logic                 i_areset_n,
   input  logic                 i_ce,
   input  logic                 i_sync,
   input  logic [2*WIDTH-1:0]   i_in,
   output logic [2*WIDTH-1:0]   o_out,
   output logic                 o_sync,
   output logic                 o_err
);

   localparam int N = 1 << LGSIZE;
   localparam logic [LGSIZE-1:0] CNT_ZERO = {LGSIZE{1'b0}};
   localparam logic [LGSIZE-1:0] CNT_ONE  = {{(LGSIZE-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_WAIT  = 2'd0,
      S_FIRST = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   function automatic logic [LGSIZE-1:0] bitrev(input logic [LGSIZE-1:0] v);
      logic [LGSIZE-1:0] r;
      r = {LGSIZE{1'b0}};
      for (int i = 0; i < LGSIZE; i++) begin
         r[i] = v[LGSIZE-1-i];
      end
      return r;
   endfunction

   state_t              r_state;
   logic [LGSIZE-1:0]   r_wrcnt;
   logic                r_wrbank;
   logic [2*WIDTH-1:0]  r_mem [0:2*N-1];
   logic [2*WIDTH-1:0]  r_out;
   logic                r_sync;
   logic                r_err;

   state_t              w_state_nx;
   logic [LGSIZE-1:0]   w_wrcnt_nx;
   logic                w_wrbank_nx;
   logic                w_we;
   logic [LGSIZE:0]     w_waddr;
   logic [LGSIZE:0]     w_raddr;
   logic                w_err;
   logic                w_sync_nx;
   logic                w_cnt_zero;
   logic                w_cnt_last;

   assign w_cnt_zero = (r_wrcnt == CNT_ZERO);
   assign w_cnt_last = &r_wrcnt;
   // The read side always works on the bank the writer is not filling.
   assign w_raddr    = {~r_wrbank, r_wrcnt};
   assign w_sync_nx  = i_ce & i_sync & w_cnt_zero & (r_state == S_RUN);

   // Next-state, write-port and alignment-error decode.
   always_comb begin
      w_state_nx  = r_state;
      w_wrcnt_nx  = r_wrcnt;
      w_wrbank_nx = r_wrbank;
      w_we        = 1'b0;
      w_waddr     = {r_wrbank, bitrev(r_wrcnt)};
      w_err       = 1'b0;
      if (i_ce) begin
         case (r_state)
            S_WAIT: begin
               if (i_sync) begin
                  w_we       = 1'b1;
                  w_waddr    = {r_wrbank, CNT_ZERO};
                  w_wrcnt_nx = CNT_ONE;
                  w_state_nx = S_FIRST;
               end else begin
                  w_wrcnt_nx = CNT_ZERO;
               end
            end
            S_FIRST, S_RUN: begin
               if (i_sync && !w_cnt_zero) begin
                  // Early sync: restart the frame in the current bank.
                  w_err      = 1'b1;
                  w_we       = 1'b1;
                  w_waddr    = {r_wrbank, CNT_ZERO};
                  w_wrcnt_nx = CNT_ONE;
                  w_state_nx = S_FIRST;
               end else if (!i_sync && w_cnt_zero) begin
                  w_err      = 1'b1;
                  w_wrcnt_nx = CNT_ZERO;
                  w_state_nx = S_WAIT;
               end else begin
                  w_we       = 1'b1;
                  w_wrcnt_nx = r_wrcnt + CNT_ONE;
                  if (w_cnt_last) begin
                     w_wrbank_nx = ~r_wrbank;
                     w_state_nx  = S_RUN;
                  end else begin
                     w_state_nx  = r_state;
                  end
               end
            end
            default: begin
               w_wrcnt_nx = CNT_ZERO;
               w_state_nx = S_WAIT;
            end
         endcase
      end else begin
         w_we = 1'b0;
      end
   end

   // Alignment state, write counter and bank select.
   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         r_state  <= S_WAIT;
         r_wrcnt  <= CNT_ZERO;
         r_wrbank <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_wrcnt  <= w_wrcnt_nx;
         r_wrbank <= w_wrbank_nx;
      end
   end

   // Frame memory write port; contents are deliberately not reset.
   always_ff @(posedge i_clk) begin
      if (w_we) begin
         r_mem[w_waddr] <= i_in;
      end
   end

   // Registered outputs; o_err is a single-clock pulse.
   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         r_out  <= {(2*WIDTH){1'b0}};
         r_sync <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         if (i_ce) begin
            r_out  <= r_mem[w_raddr];
            r_sync <= w_sync_nx;
         end
         r_err <= w_err;
      end
   end

   assign o_out  = r_out;
   assign o_sync = r_sync;
   assign o_err  = r_err;

endmodule

// File: tb/tb_unbitreverse.sv
// Directed bench for unbitreverse with N=8: natural reorder, sync errors,
// i_ce gaps and asynchronous reset.
module tb_unbitreverse;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_ce = 1'b0;
   logic        i_sync = 1'b0;
   logic [15:0] i_in = 16'd0;
   logic [15:0] o_out;
   logic        o_sync;
   logic        o_err;
   int          checks = 0;
   int          failures = 0;

   unbitreverse #(.LGSIZE(3), .WIDTH(8)) dut (
      .i_clk(clk), .i_areset_n(rst_n), .i_ce(i_ce), .i_sync(i_sync),
      .i_in(i_in), .o_out(o_out), .o_sync(o_sync), .o_err(o_err)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] br3(input logic [2:0] k);
      return {k[0], k[1], k[2]};
   endfunction

   task automatic ce_cycle(input logic ce, input logic sync, input logic [15:0] val);
      i_ce = ce; i_sync = sync; i_in = val;
      @(posedge clk); #1;
      i_ce = 1'b0; i_sync = 1'b0;
   endtask

   task automatic apply_reset;
      i_ce = 1'b0; i_sync = 1'b0; i_in = 16'd0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++; if (o_out !== 16'd0) begin failures++; $display("FAIL reset_out got=%0d exp=0", o_out); end
      checks++; if (o_sync !== 1'b0) begin failures++; $display("FAIL reset_sync got=%b exp=0", o_sync); end
      checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", o_err); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_natural_order;
      apply_reset();
      for (int k = 0; k < 8; k++) begin
         ce_cycle(1'b1, k == 0, 16'(br3(3'(k))));
         checks++; if (o_sync !== 1'b0) begin failures++; $display("FAIL t1_fill_sync k=%0d got=%b exp=0", k, o_sync); end
         checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL t1_fill_err k=%0d got=%b exp=0", k, o_err); end
      end
      for (int k = 0; k < 8; k++) begin
         ce_cycle(1'b1, k == 0, 16'(8 + br3(3'(k))));
         checks++; if (o_out !== 16'(k)) begin failures++; $display("FAIL t1_out k=%0d got=%0d exp=%0d", k, o_out, k); end
         checks++; if (o_sync !== (k == 0)) begin failures++; $display("FAIL t1_sync k=%0d got=%b exp=%b", k, o_sync, k == 0); end
         checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL t1_err k=%0d got=%b exp=0", k, o_err); end
      end
   endtask

   task automatic test_presync_discard;
      apply_reset();
      for (int k = 0; k < 5; k++) begin
         ce_cycle(1'b1, 1'b0, 16'd99);
         checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL t2_wait_err k=%0d got=%b exp=0", k, o_err); end
         checks++; if (o_sync !== 1'b0) begin failures++; $display("FAIL t2_wait_sync k=%0d got=%b exp=0", k, o_sync); end
      end
      for (int k = 0; k < 8; k++) begin
         ce_cycle(1'b1, k == 0, 16'(16 + br3(3'(k))));
         checks++; if (o_sync !== 1'b0) begin failures++; $display("FAIL t2_fill_sync k=%0d got=%b exp=0", k, o_sync); end
         checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL t2_fill_err k=%0d got=%b exp=0", k, o_err); end
      end
      for (int k = 0; k < 8; k++) begin
         ce_cycle(1'b1, k == 0, 16'(24 + br3(3'(k))));
         checks++; if (o_out !== 16'(16 + k)) begin failures++; $display("FAIL t2_out k=%0d got=%0d exp=%0d", k, o_out, 16 + k); end
         checks++; if (o_sync !== (k == 0)) begin failures++; $display("FAIL t2_sync k=%0d got=%b exp=%b", k, o_sync, k == 0); end
      end
   endtask

   task automatic test_early_sync;
      for (int k = 0; k < 3; k++) begin
         ce_cycle(1'b1, k == 0, 16'(32 + br3(3'(k))));
         checks++; if (o_out !== 16'(24 + k)) begin failures++; $display("FAIL t3_pre_out k=%0d got=%0d exp=%0d", k, o_out, 24 + k); end
         checks++; if (o_sync !== (k == 0)) begin failures++; $display("FAIL t3_pre_sync k=%0d got=%b exp=%b", k, o_sync, k == 0); end
      end
      ce_cycle(1'b1, 1'b1, 16'd40);
      checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL t3_err_pulse got=%b exp=1", o_err); end
      checks++; if (o_sync !== 1'b0) begin failures++; $display("FAIL t3_err_sync got=%b exp=0", o_sync); end
      for (int k = 1; k < 8; k++) begin
         ce_cycle(1'b1, 1'b0, 16'(40 + br3(3'(k))));
         checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL t3_refill_err k=%0d got=%b exp=0", k, o_err); end
         checks++; if (o_sync !== 1'b0) begin failures++; $display("FAIL t3_refill_sync k=%0d got=%b exp=0", k, o_sync); end
      end
      for (int k = 0; k < 8; k++) begin
         ce_cycle(1'b1, k == 0, 16'(48 + br3(3'(k))));
         checks++; if (o_out !== 16'(40 + k)) begin failures++; $display("FAIL t3_out k=%0d got=%0d exp=%0d", k, o_out, 40 + k); end
         checks++; if (o_sync !== (k == 0)) begin failures++; $display("FAIL t3_sync k=%0d got=%b exp=%b", k, o_sync, k == 0); end
         checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL t3_err k=%0d got=%b exp=0", k, o_err); end
      end
   endtask

   task automatic test_missing_sync;
      ce_cycle(1'b1, 1'b0, 16'd99);
      checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL t4_err_pulse got=%b exp=1", o_err); end
      checks++; if (o_sync !== 1'b0) begin failures++; $display("FAIL t4_err_sync got=%b exp=0", o_sync); end
      for (int k = 0; k < 3; k++) begin
         ce_cycle(1'b1, 1'b0, 16'd99);
         checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL t4_wait_err k=%0d got=%b exp=0", k, o_err); end
         checks++; if (o_sync !== 1'b0) begin failures++; $display("FAIL t4_wait_sync k=%0d got=%b exp=0", k, o_sync); end
      end
      for (int k = 0; k < 8; k++) begin
         ce_cycle(1'b1, k == 0, 16'(56 + br3(3'(k))));
         checks++; if (o_sync !== 1'b0) begin failures++; $display("FAIL t4_fill_sync k=%0d got=%b exp=0", k, o_sync); end
         checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL t4_fill_err k=%0d got=%b exp=0", k, o_err); end
      end
      for (int k = 0; k < 8; k++) begin
         ce_cycle(1'b1, k == 0, 16'(64 + br3(3'(k))));
         checks++; if (o_out !== 16'(56 + k)) begin failures++; $display("FAIL t4_out k=%0d got=%0d exp=%0d", k, o_out, 56 + k); end
         checks++; if (o_sync !== (k == 0)) begin failures++; $display("FAIL t4_sync k=%0d got=%b exp=%b", k, o_sync, k == 0); end
      end
   endtask

   task automatic test_ce_gaps;
      apply_reset();
      for (int k = 0; k < 8; k++) begin
         ce_cycle(1'b1, k == 0, 16'(br3(3'(k))));
         checks++; if (o_sync !== 1'b0) begin failures++; $display("FAIL t5_fill_sync k=%0d got=%b exp=0", k, o_sync); end
         repeat (2) ce_cycle(1'b0, 1'b1, 16'hBEEF);
      end
      for (int k = 0; k < 8; k++) begin
         ce_cycle(1'b1, k == 0, 16'(8 + br3(3'(k))));
         checks++; if (o_out !== 16'(k)) begin failures++; $display("FAIL t5_out k=%0d got=%0d exp=%0d", k, o_out, k); end
         checks++; if (o_sync !== (k == 0)) begin failures++; $display("FAIL t5_sync k=%0d got=%b exp=%b", k, o_sync, k == 0); end
         for (int g = 0; g < 2; g++) begin
            ce_cycle(1'b0, 1'b1, 16'hBEEF);
            checks++; if (o_out !== 16'(k)) begin failures++; $display("FAIL t5_hold_out k=%0d g=%0d got=%0d exp=%0d", k, g, o_out, k); end
            checks++; if (o_sync !== (k == 0)) begin failures++; $display("FAIL t5_hold_sync k=%0d g=%0d got=%b exp=%b", k, g, o_sync, k == 0); end
            checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL t5_hold_err k=%0d g=%0d got=%b exp=0", k, g, o_err); end
         end
      end
   endtask

   task automatic test_async_reset;
      ce_cycle(1'b1, 1'b1, 16'd16);
      checks++; if (o_out !== 16'd8) begin failures++; $display("FAIL t6_pre_out got=%0d exp=8", o_out); end
      checks++; if (o_sync !== 1'b1) begin failures++; $display("FAIL t6_pre_sync got=%b exp=1", o_sync); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (o_out !== 16'd0) begin failures++; $display("FAIL t6_rst_out got=%0d exp=0", o_out); end
      checks++; if (o_sync !== 1'b0) begin failures++; $display("FAIL t6_rst_sync got=%b exp=0", o_sync); end
      checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL t6_rst_err got=%b exp=0", o_err); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         ce_cycle(1'b1, k == 0, 16'(32 + br3(3'(k))));
         checks++; if (o_sync !== 1'b0) begin failures++; $display("FAIL t6_fill_sync k=%0d got=%b exp=0", k, o_sync); end
         checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL t6_fill_err k=%0d got=%b exp=0", k, o_err); end
      end
      for (int k = 0; k < 8; k++) begin
         ce_cycle(1'b1, k == 0, 16'(40 + br3(3'(k))));
         checks++; if (o_out !== 16'(32 + k)) begin failures++; $display("FAIL t6_out k=%0d got=%0d exp=%0d", k, o_out, 32 + k); end
         checks++; if (o_sync !== (k == 0)) begin failures++; $display("FAIL t6_sync k=%0d got=%b exp=%b", k, o_sync, k == 0); end
      end
   endtask

   initial begin
      test_reset();
      test_natural_order();
      test_presync_discard();
      test_early_sync();
      test_missing_sync();
      test_ce_gaps();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
